mcpu_bram_mc: RTL
=================

# mcpu_bram_mc

Block-RAM-backed responder for the `ltc2mc` Avalon-MM burst port that `MCPU_int` drives as initiator. It stands in for the external LPDDR2 controller so the core has real memory on the bench and in FPGA builds without DDR. It accepts burst reads and writes of 128-bit beats and returns read data with a fixed pipeline latency. After every reset it zero-fills its storage and then raises `mc_ready`.

## Interface
- `DEPTH_LOG2`, default 10: storage is 2^DEPTH_LOG2 words of 128 bits. Only `addr[DEPTH_LOG2-1:0]` is decoded; upper address bits alias.
- `INIT_CLEAR`, default 1: 1 = zero-fill memory after reset; 0 = skip the fill and go ready immediately.
- `clkrst_mem_clk` in 1: the only clock.
- `clkrst_mem_rst` in 1: reset. Synchronous to `clkrst_mem_clk`, active-high.
- `ltc2mc_avl_addr_0` in 25: word address of beat 0.
- `ltc2mc_avl_be_0` in 16: byte enables for write beats. Bit i enables `wdata[8i+7:8i]`.
- `ltc2mc_avl_burstbegin_0` in 1: marks the first beat or command of a burst.
- `ltc2mc_avl_read_req_0` in 1: read command.
- `ltc2mc_avl_write_req_0` in 1: write beat valid.
- `ltc2mc_avl_size_0` in 5: burst length in beats, 1–31. A value of 0 is treated as 1.
- `ltc2mc_avl_wdata_0` in 128: write data.
- `ltc2mc_avl_ready_0` out 1: responder can accept a command or beat this cycle.
- `ltc2mc_avl_rdata_0` out 128: read data.
- `ltc2mc_avl_rdata_valid_0` out 1: `rdata` is valid this cycle.
- `mc_ready` out 1: initialization is complete.
- `proto_err` out 1: sticky protocol-violation flag. Cleared only by reset.

## Operation
- States are INIT, IDLE, WBURST and RBURST.
- **Reset.** Reset forces the state to INIT, clears the beat counter, and cancels the read pipeline. Memory contents are retained apart from the INIT fill.
- **INIT.** One word is cleared per cycle, from address 0 up to 2^DEPTH_LOG2−1. `ready` is 0 throughout. After the last word the state goes to IDLE and `mc_ready` goes to 1.
  - With `INIT_CLEAR=0`, INIT lasts exactly one cycle.
- **IDLE.** `ready` is 1. A request with `ready=1` is accepted.
  - On `write_req`: latch the base address and length L = max(size,1). Beat 0 is written this cycle. If L>1, go to WBURST.
  - On `read_req` (without `write_req`): latch base and L. Beat 0 is issued this cycle. Go to RBURST.
  - If both are asserted: the write wins, the read is dropped, and `proto_err` is set.
  - A request without `burstbegin` is still accepted as a burst start, and `proto_err` is set.
- **WBURST.** `ready` is 1. Each cycle with `write_req=1` writes beat n to mem[(base+n) mod 2^DEPTH_LOG2], merged under `be`. Cycles with `write_req=0` are stalls with no effect. After beat L−1, go to IDLE.
  - `read_req` in this state is ignored and sets `proto_err`.
  - `burstbegin` in this state sets `proto_err`, and the beat is still treated as a continuation.
- **RBURST.** `ready` is 0. One beat is issued per cycle at (base+n) mod 2^DEPTH_LOG2, with no gaps. Return to IDLE once the last beat's `rdata_valid` has been driven.
- **Address arithmetic.** Base plus beat index is computed in DEPTH_LOG2 bits and wraps silently.
- **Byte enables.** Write beats with `be=0` consume a beat but change nothing.

## Timing
- All outputs are registered.
- **Reset values:**
  - `ready`=0
  - `rdata_valid`=0
  - `rdata`=0
  - `mc_ready`=0
  - `proto_err`=0
- **INIT duration.** With the clear enabled, `ready` and `mc_ready` first read 1 in the cycle 2^DEPTH_LOG2+1 after the reset cycle.
- **Read latency.** A read accepted at cycle T returns beat i with `rdata_valid=1` at T+2+i, for i = 0..L−1, contiguously.
  - `ready` is 0 from T+1 through T+L+1.
  - `ready` returns to 1 at T+L+2.
- **Write visibility.** A write beat at cycle T is visible to a read issued at T+1 or later. There is no read-during-write hazard, because reads cannot overlap writes.
- **Back-to-back writes.** A new write burst may start in the cycle immediately after the last beat of the previous burst.
- **Reset mid-burst.** Any `rdata_valid` still in flight is suppressed from the cycle after reset. A partially written burst keeps the beats already written.

## Test plan
- **Init.** `DEPTH_LOG2`=4. Assert reset for 1 cycle → `ready` and `mc_ready` rise at cycle 17. A 16-beat read from address 0 then returns all zeros.
- **Byte-enable write then read.**
  - Write: addr 5, size 2, beats `0x…AA` and `0x…BB`, `be`=16'hFFFF then 16'h000F, with a 3-cycle `write_req` stall between the beats.
  - Read: addr 5, size 2 → `rdata_valid` at T+2 and T+3. Beat 0 is `0x…AA`. Beat 1 has only bytes 0–3 equal to `BB`; the rest are zero.
  - `ready` is 0 from T+1 to T+3.
- **Wrap.** `DEPTH_LOG2`=4. Write addr 15, size 3 with values 1, 2, 3 → mem[15]=1, mem[0]=2, mem[1]=3. A read of addr 0x10 (which aliases to 0) with size 1 returns 2.
- **Size 0.** Write and read with size=0 → each behaves as a single beat. `ready` returns at T+3.
- **Protocol errors.** Check each case:
  - `read_req` and `write_req` together in IDLE → the write is performed, no `rdata_valid` appears, and `proto_err`=1 and stays 1.
  - `read_req` during WBURST → ignored, and `proto_err` is set.
- **Reset mid-read.** Issue a 4-beat read and assert reset at T+3 → no `rdata_valid` after T+3, and the block re-enters INIT.

Source files
------------

// File: rtl/mcpu_bram_mc_if.sv
// Avalon-MM burst port between the MCPU initiator and its memory responder.
interface mcpu_bram_mc_if;
    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned SIZE_W = 5;

    logic [ADDR_W-1:0] ltc2mc_avl_addr_0;
    logic [BE_W-1:0]   ltc2mc_avl_be_0;
    logic              ltc2mc_avl_burstbegin_0;
    logic              ltc2mc_avl_read_req_0;
    logic              ltc2mc_avl_write_req_0;
    logic [SIZE_W-1:0] ltc2mc_avl_size_0;
    logic [DATA_W-1:0] ltc2mc_avl_wdata_0;
    logic              ltc2mc_avl_ready_0;
    logic [DATA_W-1:0] ltc2mc_avl_rdata_0;
    logic              ltc2mc_avl_rdata_valid_0;

    modport master (
        output ltc2mc_avl_addr_0, ltc2mc_avl_be_0, ltc2mc_avl_burstbegin_0,
               ltc2mc_avl_read_req_0, ltc2mc_avl_write_req_0, ltc2mc_avl_size_0,
               ltc2mc_avl_wdata_0,
        input  ltc2mc_avl_ready_0, ltc2mc_avl_rdata_0, ltc2mc_avl_rdata_valid_0
    );

    modport slave (
        input  ltc2mc_avl_addr_0, ltc2mc_avl_be_0, ltc2mc_avl_burstbegin_0,
               ltc2mc_avl_read_req_0, ltc2mc_avl_write_req_0, ltc2mc_avl_size_0,
               ltc2mc_avl_wdata_0,
        output ltc2mc_avl_ready_0, ltc2mc_avl_rdata_0, ltc2mc_avl_rdata_valid_0
    );
endinterface

// File: rtl/mcpu_bram_mc.sv
// Block-RAM responder for the ltc2mc Avalon-MM burst port; zero-fills after reset,
// accepts 128-bit write bursts and returns read bursts with a two-cycle latency.
module mcpu_bram_mc #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic                 clkrst_mem_clk,
    input  logic                 clkrst_mem_rst,
    mcpu_bram_mc_if.slave        avl,
    output logic                 mc_ready,
    output logic                 proto_err
);
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = (DEPTH_LOG2 > 6) ? DEPTH_LOG2 : 6;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_WBURST = 2'd2;
    localparam logic [1:0] ST_RBURST = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [DEPTH_LOG2-1:0] base_q, base_d;
    logic                  ready_q, ready_d;
    logic                  mc_ready_q, mc_ready_d;
    logic                  proto_err_q, proto_err_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     mem_rd_q;

    logic                  wr_en_c;
    logic [DEPTH_LOG2-1:0] wr_addr_c;
    logic [DATA_W-1:0]     wr_data_c;
    logic [BE_W-1:0]       wr_be_c;
    logic                  rd_en_c;
    logic [DEPTH_LOG2-1:0] rd_addr_c;
    logic [DEPTH_LOG2-1:0] beat_addr_c;
    logic [DEPTH_LOG2-1:0] req_addr_c;
    logic [CNT_W-1:0]      req_len_c;
    logic                  addr_unused_c;

    // Upper address bits alias onto the decoded range.
    assign addr_unused_c = ^avl.ltc2mc_avl_addr_0[24:DEPTH_LOG2];
    assign req_addr_c    = avl.ltc2mc_avl_addr_0[DEPTH_LOG2-1:0];
    assign req_len_c     = (avl.ltc2mc_avl_size_0 == 5'd0) ? CNT_W'(1)
                                                           : CNT_W'(avl.ltc2mc_avl_size_0);
    assign beat_addr_c   = base_q + cnt_q[DEPTH_LOG2-1:0];

    // Next-state, memory port control and registered-output next values.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        base_d        = base_q;
        ready_d       = ready_q;
        mc_ready_d    = mc_ready_q;
        proto_err_d   = proto_err_q;
        s1_valid_d    = 1'b0;
        rdata_valid_d = s1_valid_q;
        rdata_d       = s1_valid_q ? mem_rd_q : rdata_q;
        wr_en_c       = 1'b0;
        wr_addr_c     = beat_addr_c;
        wr_data_c     = avl.ltc2mc_avl_wdata_0;
        wr_be_c       = avl.ltc2mc_avl_be_0;
        rd_en_c       = 1'b0;
        rd_addr_c     = beat_addr_c;

        case (state_q)
            ST_INIT: begin
                ready_d = 1'b0;
                if (INIT_CLEAR) begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = cnt_q[DEPTH_LOG2-1:0];
                    wr_data_c = '0;
                    wr_be_c   = '1;
                end
                if (!INIT_CLEAR || (cnt_q == CNT_W'(DEPTH - 1))) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    ready_d    = 1'b1;
                    mc_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                if (avl.ltc2mc_avl_write_req_0 || avl.ltc2mc_avl_read_req_0) begin
                    if (!avl.ltc2mc_avl_burstbegin_0) proto_err_d = 1'b1;
                    base_d = req_addr_c;
                    len_d  = req_len_c;
                    cnt_d  = CNT_W'(1);
                    if (avl.ltc2mc_avl_write_req_0) begin
                        // A simultaneous read is dropped in favour of the write.
                        if (avl.ltc2mc_avl_read_req_0) proto_err_d = 1'b1;
                        wr_en_c   = 1'b1;
                        wr_addr_c = req_addr_c;
                        if (req_len_c != CNT_W'(1)) state_d = ST_WBURST;
                        else                         cnt_d   = '0;
                    end else begin
                        rd_en_c    = 1'b1;
                        rd_addr_c  = req_addr_c;
                        s1_valid_d = 1'b1;
                        ready_d    = 1'b0;
                        state_d    = ST_RBURST;
                    end
                end
            end

            ST_WBURST: begin
                if (avl.ltc2mc_avl_read_req_0 || avl.ltc2mc_avl_burstbegin_0) proto_err_d = 1'b1;
                if (avl.ltc2mc_avl_write_req_0) begin
                    wr_en_c = 1'b1;
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_RBURST: begin
                // Beats issue while cnt < len; two more cycles drain the pipeline.
                if (cnt_q < len_q) begin
                    rd_en_c    = 1'b1;
                    s1_valid_d = 1'b1;
                end
                if (cnt_q == len_q + CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clkrst_mem_clk) begin
        if (clkrst_mem_rst) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            len_q         <= '0;
            base_q        <= '0;
            ready_q       <= 1'b0;
            mc_ready_q    <= 1'b0;
            proto_err_q   <= 1'b0;
            s1_valid_q    <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            base_q        <= base_d;
            ready_q       <= ready_d;
            mc_ready_q    <= mc_ready_d;
            proto_err_q   <= proto_err_d;
            s1_valid_q    <= s1_valid_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
        end
    end

    // Storage: byte-masked write port and registered read port.
    always_ff @(posedge clkrst_mem_clk) begin
        if (wr_en_c && !clkrst_mem_rst) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (wr_be_c[b]) mem[wr_addr_c][8*b +: 8] <= wr_data_c[8*b +: 8];
            end
        end
        if (rd_en_c) mem_rd_q <= mem[rd_addr_c];
    end

    assign avl.ltc2mc_avl_ready_0       = ready_q;
    assign avl.ltc2mc_avl_rdata_0       = rdata_q;
    assign avl.ltc2mc_avl_rdata_valid_0 = rdata_valid_q;
    assign mc_ready                     = mc_ready_q;
    assign proto_err                    = proto_err_q;
endmodule
